// File: rtl/fetch_prefetch_unit_pkg.sv
// rtl/fetch_prefetch_unit_pkg.sv - shared constants and helpers for the fetch front end
// Purpose: default reset PC, NOP encoding, PC step and instruction width
//          shared by fetch_prefetch_unit and fetch_queue.
// Ports:   none (package).
package fetch_prefetch_unit_pkg;

  localparam int          INSTR_W         = 32;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP         = 32'd4;

  // Instructions are word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO holding {instr, pc} entries
// Purpose: DEPTH-entry FIFO with flush; flush wins over push and pop.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   push, push_data  - write an entry at the tail
//   pop              - drop the head entry
//   flush            - empty the queue
//   count            - number of stored entries (0..DEPTH)
//   head_data        - entry at the head (meaningless when count = 0)
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are power-of-two wide and wrap on their own.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch front end with prefetch queue
// Purpose: owns the fetch PC, issues one imem read per cycle while queue
//          space remains, buffers returning words and hands them to decode.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   imem_addr, imem_read    - read request to the synchronous instruction memory
//   imem_data               - read data, valid the cycle after imem_read
//   redirect, redirect_pc   - taken branch from the write stage and its target
//   stall                   - decode cannot accept this cycle
//   valid_D, instr_D, pc_D  - head instruction and its address for decode
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        imem_addr,
  output logic               imem_read,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  output logic               valid_D,
  output logic [INSTR_W-1:0] instr_D,
  output logic [31:0]        pc_D
);

  logic [31:0]          fetch_pc;
  logic [31:0]          issued_pc;
  logic                 req_q;
  logic [CW-1:0]        q_count;
  logic [INSTR_W+31:0]  head_data;
  logic                 pop;
  logic                 push;
  logic [CW:0]          occupancy;

  assign valid_D = (q_count != '0);
  assign pop     = valid_D && !stall;
  assign push    = req_q && !redirect;

  // Entries already stored plus the read still in flight, minus what decode
  // takes this cycle; a new read is only issued if it is guaranteed a slot.
  assign occupancy = {1'b0, q_count} + (CW+1)'(req_q) - (CW+1)'(pop);
  assign imem_read = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  assign instr_D = valid_D ? head_data[INSTR_W+31:32] : NOP_INSTR;
  assign pc_D    = valid_D ? head_data[31:0] : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
      req_q     <= 1'b0;
    end else if (redirect) begin
      // The in-flight read (if any) is forgotten by clearing req_q.
      fetch_pc <= align_pc(redirect_pc);
      req_q    <= 1'b0;
    end else begin
      req_q <= imem_read;
      if (imem_read) begin
        issued_pc <= fetch_pc;
        fetch_pc  <= fetch_pc + PC_STEP;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + 32)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_data, issued_pc}),
    .pop       (pop),
    .flush     (redirect),
    .count     (q_count),
    .head_data (head_data)
  );

endmodule
